// File: rtl/coreUtils.sv
// Shared constants and types for the instruction fetch path.
package coreUtils;

    localparam logic [31:0] NOP              = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam int unsigned FQ_DEPTH_DEFAULT = 2;

    // One fetched instruction together with the address it came from.
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fq_entry_t;

    // Bypass is an absolute jump (halfword bit dropped); branch is base-relative.
    function automatic logic [31:0] redirect_target(
        input logic        bypass,
        input logic [31:0] pc_next,
        input logic [31:0] pc_base
    );
        if (bypass) begin
            return {pc_next[31:1], 1'b0};
        end
        return pc_base + pc_next;
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Small circular FIFO holding fetched instructions between memory and decode.
module fetch_queue
    import coreUtils::*;
#(
    parameter int unsigned DEPTH = FQ_DEPTH_DEFAULT
) (
    input  logic                         i_clk,
    input  logic                         i_nreset,
    input  logic                         i_clear,
    input  logic                         i_push,
    input  logic                         i_pop,
    input  fq_entry_t                    i_data,
    output fq_entry_t                    o_data,
    output logic                         o_full,
    output logic                         o_empty,
    output logic [$clog2(DEPTH+1)-1:0]   o_count
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fq_entry_t        r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_do_push;
    logic w_do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        if (ptr == PTR_W'(DEPTH - 1)) begin
            return '0;
        end
        return ptr + 1'b1;
    endfunction

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_count   = r_count;
    assign o_data    = r_mem[r_rd_ptr];

    // A full queue still accepts a push when the head leaves in the same cycle.
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    // Entry storage; contents are only observed through the count, so no reset.
    always_ff @(posedge i_clk) begin
        if (w_do_push && !i_clear) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointer and occupancy tracking; clear empties the queue in one cycle.
    always_ff @(posedge i_clk or negedge i_nreset) begin
        if (!i_nreset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_do_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_do_pop && !w_do_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    // The upstream request gate reserves a slot per request, so this never fires.
    a_no_overflow: assert property (
        @(posedge i_clk) disable iff (!i_nreset) !(i_push && o_full && !i_pop)
    );

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues word fetches, queues responses, feeds IF/ID.
module fetch_unit
    import coreUtils::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int unsigned FQ_DEPTH = FQ_DEPTH_DEFAULT
) (
    input  logic        Clock,
    input  logic        nReset,
    input  logic        hold,
    input  logic        flush,
    input  logic        branch,
    input  logic        bypass,
    input  logic [31:0] PCnext,
    input  logic [31:0] PCbase,
    output logic        imemReq,
    output logic [31:0] imemAddr,
    input  logic        imemReady,
    input  logic        imemRespValid,
    input  logic [31:0] imemRdata,
    output logic        validID,
    output logic [31:0] instrID,
    output logic [31:0] PCID
);

    localparam int unsigned CNT_W = $clog2(FQ_DEPTH + 1);

    logic [31:0]      r_pc_f;
    logic [31:0]      r_resp_pc;
    logic [CNT_W-1:0] r_outstanding;
    logic [CNT_W-1:0] r_drop_count;
    logic             r_valid_id;
    logic [31:0]      r_instr_id;
    logic [31:0]      r_pc_id;

    logic             w_redirect;
    logic [31:0]      w_target;
    logic             w_accept;
    logic             w_push;
    logic             w_pop;
    logic             w_fq_empty;
    logic             w_fq_full;
    logic [CNT_W-1:0] w_fq_count;
    logic [CNT_W:0]   w_in_use;
    fq_entry_t        w_push_data;
    fq_entry_t        w_head;

    assign w_redirect = branch || bypass;
    assign w_target   = redirect_target(bypass, PCnext, PCbase);

    // Every in-flight request owns a queue slot, so the queue can never overflow.
    assign w_in_use   = {1'b0, w_fq_count} + {1'b0, r_outstanding};
    assign imemReq    = nReset && !w_redirect && !w_fq_full
                        && (w_in_use < (CNT_W + 1)'(FQ_DEPTH));
    assign imemAddr   = r_pc_f;
    assign w_accept   = imemReq && imemReady;

    // Responses in a redirect cycle or owed to an older stream are discarded.
    assign w_push      = imemRespValid && !w_redirect && (r_drop_count == '0);
    assign w_push_data = '{instr: imemRdata, pc: r_resp_pc};

    // Head moves into IF/ID only when decode is neither flushed nor stalled.
    assign w_pop      = !flush && !w_redirect && !hold && !w_fq_empty;

    fetch_queue #(
        .DEPTH (FQ_DEPTH)
    ) u_fetch_queue (
        .i_clk    (Clock),
        .i_nreset (nReset),
        .i_clear  (w_redirect),
        .i_push   (w_push),
        .i_pop    (w_pop),
        .i_data   (w_push_data),
        .o_data   (w_head),
        .o_full   (w_fq_full),
        .o_empty  (w_fq_empty),
        .o_count  (w_fq_count)
    );

    // Fetch PC: jump on redirect, otherwise step one word per accepted request.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            r_pc_f <= RESET_PC;
        end else if (w_redirect) begin
            r_pc_f <= w_target;
        end else if (w_accept) begin
            r_pc_f <= r_pc_f + 32'd4;
        end
    end

    // Response PC tags each kept response with the address it was fetched from.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            r_resp_pc <= RESET_PC;
        end else if (w_redirect) begin
            r_resp_pc <= w_target;
        end else if (w_push) begin
            r_resp_pc <= r_resp_pc + 32'd4;
        end
    end

    // In-flight request count, including ones that will be dropped.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            r_outstanding <= '0;
        end else begin
            r_outstanding <= r_outstanding + CNT_W'(w_accept) - CNT_W'(imemRespValid);
        end
    end

    // Stale responses still to be discarded after the latest redirect.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            r_drop_count <= '0;
        end else if (w_redirect) begin
            r_drop_count <= r_outstanding - CNT_W'(imemRespValid);
        end else if (imemRespValid && (r_drop_count != '0)) begin
            r_drop_count <= r_drop_count - 1'b1;
        end
    end

    // IF/ID register: flush/redirect bubble, hold freezes, else pop or bubble.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            r_valid_id <= 1'b0;
            r_instr_id <= NOP;
            r_pc_id    <= '0;
        end else if (flush || w_redirect) begin
            r_valid_id <= 1'b0;
            r_instr_id <= NOP;
        end else if (!hold) begin
            if (!w_fq_empty) begin
                r_valid_id <= 1'b1;
                r_instr_id <= w_head.instr;
                r_pc_id    <= w_head.pc;
            end else begin
                r_valid_id <= 1'b0;
                r_instr_id <= NOP;
            end
        end
    end

    assign validID = r_valid_id;
    assign instrID = r_instr_id;
    assign PCID    = r_pc_id;

endmodule

// File: tb/tb_fetch_unit.sv
// Randomised bench for fetch_unit with an in-order memory and a stream-level model.
module tb_fetch_unit;
    import coreUtils::*;

    localparam int unsigned DEPTH = 2;
    localparam logic [31:0] RPC   = 32'h0000_0000;

    logic        Clock = 1'b0;
    logic        nReset = 1'b0;
    logic        hold = 1'b0, flush = 1'b0, branch = 1'b0, bypass = 1'b0;
    logic [31:0] PCnext = '0, PCbase = '0;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic        imemReady = 1'b0;
    logic        imemRespValid = 1'b0;
    logic [31:0] imemRdata = '0;
    logic        validID;
    logic [31:0] instrID;
    logic [31:0] PCID;

    fetch_unit #(
        .RESET_PC (RPC),
        .FQ_DEPTH (DEPTH)
    ) dut (
        .Clock         (Clock),
        .nReset        (nReset),
        .hold          (hold),
        .flush         (flush),
        .branch        (branch),
        .bypass        (bypass),
        .PCnext        (PCnext),
        .PCbase        (PCbase),
        .imemReq       (imemReq),
        .imemAddr      (imemAddr),
        .imemReady     (imemReady),
        .imemRespValid (imemRespValid),
        .imemRdata     (imemRdata),
        .validID       (validID),
        .instrID       (instrID),
        .PCID          (PCID)
    );

    always #5 Clock = ~Clock;

    // Memory side: requests awaiting a response, marked stale once redirected away.
    typedef struct {
        logic [31:0] addr;
        int unsigned due;
        bit          stale;
    } req_t;

    // Decode side: instructions fetched for the current stream, in order.
    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    req_t        pend[$];
    ent_t        mq[$];
    logic [31:0] m_pcf;
    bit          m_valid;
    logic [31:0] m_instr;
    logic [31:0] m_pcid;
    int unsigned cyc = 0;
    int unsigned lat_min = 1, lat_max = 1, resp_pct = 100;
    int          n_total = 0;
    int          n_bad = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return (addr * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        pend.delete();
        mq.delete();
        m_pcf   = RPC;
        m_valid = 1'b0;
        m_instr = NOP;
        m_pcid  = '0;
    endtask

    // Asynchronous reset mid-cycle; outputs must take reset values at once.
    task automatic do_reset();
        @(negedge Clock);
        #2;
        nReset = 1'b0;
        {hold, flush, branch, bypass, imemReady, imemRespValid} = '0;
        #1;
        check_eq("rst_req", 32'(imemReq), 32'd0);
        check_eq("rst_addr", imemAddr, RPC);
        check_eq("rst_valid", 32'(validID), 32'd0);
        check_eq("rst_instr", instrID, NOP);
        check_eq("rst_pcid", PCID, 32'd0);
        model_reset();
        repeat (2) @(negedge Clock);
        nReset = 1'b1;
    endtask

    // One clock cycle: check IF/ID, drive inputs, check fetch outputs, advance model.
    task automatic step(input bit h, input bit f, input bit br, input bit bp,
                        input logic [31:0] pcn, input logic [31:0] pcb, input bit rdy);
        bit          rv;
        bit          redirect;
        bit          exp_req;
        bit          acc;
        logic [31:0] target;
        ent_t        e;
        req_t        r;

        check_eq("id_valid", 32'(validID), 32'(m_valid));
        check_eq("id_instr", instrID, m_instr);
        if (m_valid) check_eq("id_pc", PCID, m_pcid);

        rv = (pend.size() > 0) && (pend[0].due <= cyc) && ($urandom_range(0, 99) < resp_pct);
        hold = h; flush = f; branch = br; bypass = bp;
        PCnext = pcn; PCbase = pcb; imemReady = rdy;
        imemRespValid = rv;
        imemRdata = rv ? mem_word(pend[0].addr) : $urandom;

        redirect = br || bp;
        target   = bp ? (pcn & 32'hFFFF_FFFE) : (pcb + pcn);
        exp_req  = ((mq.size() + pend.size()) < DEPTH) && !redirect;
        acc      = exp_req && rdy;

        #1;
        check_eq("req", 32'(imemReq), 32'(exp_req));
        check_eq("addr", imemAddr, m_pcf);

        if (f || redirect) begin
            m_valid = 1'b0;
            m_instr = NOP;
        end else if (!h) begin
            if (mq.size() > 0) begin
                e = mq.pop_front();
                m_valid = 1'b1;
                m_instr = e.instr;
                m_pcid  = e.pc;
            end else begin
                m_valid = 1'b0;
                m_instr = NOP;
            end
        end
        if (redirect) mq.delete();
        if (rv) begin
            r = pend.pop_front();
            if (!redirect && !r.stale) begin
                e.pc = r.addr;
                e.instr = mem_word(r.addr);
                mq.push_back(e);
            end
        end
        if (redirect) begin
            for (int i = 0; i < pend.size(); i++) pend[i].stale = 1'b1;
        end
        if (acc) begin
            r.addr  = m_pcf;
            r.due   = cyc + $urandom_range(lat_min, lat_max);
            r.stale = 1'b0;
            pend.push_back(r);
        end
        if (redirect) m_pcf = target;
        else if (acc) m_pcf = m_pcf + 32'd4;
        cyc++;
        @(negedge Clock);
    endtask

    initial begin
        bit          h, f, br, bp, rdy;
        logic [31:0] pcn, pcb;

        do_reset();

        // Free-running fetch with single-cycle memory.
        repeat (8) step(0, 0, 0, 0, '0, '0, 1);

        // Decode stall long enough to fill the queue, then release.
        repeat (3) step(1, 0, 0, 0, '0, '0, 1);
        repeat (6) step(0, 0, 0, 0, '0, '0, 1);

        // Relative branch with two requests still in flight.
        lat_min = 4; lat_max = 4;
        for (int i = 0; i < 10 && pend.size() < 2; i++) step(0, 0, 0, 0, '0, '0, 1);
        check_eq("two_in_flight", 32'(pend.size()), 32'd2);
        step(0, 0, 1, 0, 32'h20, 32'h100, 1);
        check_eq("branch_addr", imemAddr, 32'h120);
        repeat (14) step(0, 0, 0, 0, '0, '0, 1);

        // Bypass wins over a simultaneous branch and drops bit 0.
        step(0, 0, 1, 1, 32'h203, 32'h500, 1);
        check_eq("bypass_addr", imemAddr, 32'h202);
        lat_min = 1; lat_max = 1;
        repeat (10) step(0, 0, 0, 0, '0, '0, 1);

        // Flush beats hold.
        step(1, 1, 0, 0, '0, '0, 1);
        check_eq("flush_valid", 32'(validID), 32'd0);
        check_eq("flush_instr", instrID, NOP);
        repeat (4) step(0, 0, 0, 0, '0, '0, 1);

        // Memory not ready: address must not move.
        repeat (5) step(0, 0, 0, 0, '0, '0, 0);
        repeat (4) step(0, 0, 0, 0, '0, '0, 1);

        // Randomised traffic with variable latency and a mid-run reset.
        do_reset();
        lat_min = 1; lat_max = 4; resp_pct = 70;
        for (int n = 0; n < 3000; n++) begin
            if (n == 1500) do_reset();
            h   = ($urandom_range(0, 99) < 15);
            f   = ($urandom_range(0, 99) < 5);
            br  = ($urandom_range(0, 99) < 4);
            bp  = ($urandom_range(0, 99) < 3);
            rdy = ($urandom_range(0, 99) < 75);
            pcn = ($urandom_range(0, 3) == 0) ? 32'($urandom) : 32'($urandom_range(0, 4095));
            pcb = 32'($urandom);
            step(h, f, br, bp, pcn, pcb, rdy);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
